// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit processor front end.
// Holds the word width, the opcode field layout, the HALT opcode,
// the fetch FSM state encoding and a PC alignment helper.
package proc_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned OPC_W  = 5;

  // Opcode held in instr[15:11]
  localparam logic [OPC_W-1:0] OPC_HALT = 5'b00000;

  typedef enum logic [1:0] {
    ST_START  = 2'd0,
    ST_REQ    = 2'd1,
    ST_HOLD   = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  // Instructions are halfword aligned: bit 0 of any used PC is always 0
  function automatic logic [WORD_W-1:0] align_pc(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Architectural PC register with load and +2 increment.
// Ports:
//   clk, rst      - clock, async active-low reset (loads RESET_PC)
//   load, load_pc - load a new PC (bit 0 forced to 0)
//   inc           - advance PC by 2 (ignored when load is set)
//   pc, pc_plus2  - registered PC and PC+2 (mod 2^16)
module pc_reg
  import proc_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] load_pc,
  input  logic              inc,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] pc_plus2
);

  logic [WORD_W-1:0] next_pc;

  // Load wins over increment; pc_plus2 is kept registered alongside pc
  always_comb begin
    next_pc = load ? align_pc(load_pc) : pc_plus2;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= RESET_PC;
      pc_plus2 <= RESET_PC + WORD_W'(2);
    end else if (load || inc) begin
      pc       <= next_pc;
      pc_plus2 <= next_pc + WORD_W'(2);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time,
// latches the returned word and hands it to decode; handles redirects
// (squashing an outstanding fetch) and stops after handing off HALT.
// Ports:
//   clk, rst                      - clock, async active-low reset
//   imem_req/addr/rdy/data        - instruction memory handshake
//   instr_valid, dec_ready        - decode handshake (handoff = both high)
//   instr, pc, pc_plus2           - instruction register and its address
//   redirect_valid, redirect_pc   - PC change request from execute
//   halted, err_align, fetch_count- status
module fetch_unit
  import proc_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 16'h0000,
  parameter logic [OPC_W-1:0]  HALT_OPC = OPC_HALT
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_rdy,
  input  logic [WORD_W-1:0] imem_data,
  output logic              instr_valid,
  input  logic              dec_ready,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] pc_plus2,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              halted,
  output logic              err_align,
  output logic [WORD_W-1:0] fetch_count
);

  fetch_state_e      state, state_n;
  logic              req_n, valid_n, halted_n, err_n, squash, squash_n;
  logic [WORD_W-1:0] instr_n, count_n, pend_pc, pend_n;
  logic              pc_load, pc_inc, handoff;
  logic [WORD_W-1:0] load_val;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load),
    .load_pc  (load_val),
    .inc      (pc_inc),
    .pc       (pc),
    .pc_plus2 (pc_plus2)
  );

  // The PC register is the fetch address while a request is outstanding
  assign imem_addr = pc;
  assign handoff   = instr_valid & dec_ready;

  // Next-state and next-output logic
  always_comb begin
    state_n  = state;
    req_n    = imem_req;
    valid_n  = instr_valid;
    halted_n = halted;
    instr_n  = instr;
    count_n  = fetch_count;
    squash_n = squash;
    pend_n   = pend_pc;
    err_n    = err_align;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    load_val = redirect_pc;

    if (redirect_valid && redirect_pc[0] && state != ST_HALTED) begin
      err_n = 1'b1;
    end

    unique case (state)
      ST_START: begin
        pc_load = redirect_valid;
        state_n = ST_REQ;
        req_n   = 1'b1;
      end
      ST_REQ: begin
        if (imem_rdy) begin
          if (redirect_valid) begin
            // Returned word belongs to the old path; reissue at the target
            pc_load  = 1'b1;
            squash_n = 1'b0;
          end else if (squash) begin
            pc_load  = 1'b1;
            load_val = pend_pc;
            squash_n = 1'b0;
          end else begin
            instr_n = imem_data;
            state_n = ST_HOLD;
            req_n   = 1'b0;
            valid_n = 1'b1;
          end
        end else if (redirect_valid) begin
          // Address must stay stable; remember the target until data returns
          squash_n = 1'b1;
          pend_n   = align_pc(redirect_pc);
        end
      end
      ST_HOLD: begin
        if (handoff) begin
          count_n = fetch_count + WORD_W'(1);
        end
        if (redirect_valid) begin
          pc_load = 1'b1;
          state_n = ST_REQ;
          req_n   = 1'b1;
          valid_n = 1'b0;
        end else if (handoff) begin
          valid_n = 1'b0;
          if (instr[WORD_W-1 -: OPC_W] == HALT_OPC) begin
            state_n  = ST_HALTED;
            halted_n = 1'b1;
          end else begin
            pc_inc  = 1'b1;
            state_n = ST_REQ;
            req_n   = 1'b1;
          end
        end
      end
      ST_HALTED: begin
        req_n   = 1'b0;
        valid_n = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_START;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      err_align   <= 1'b0;
      instr       <= '0;
      fetch_count <= '0;
      squash      <= 1'b0;
      pend_pc     <= '0;
    end else begin
      state       <= state_n;
      imem_req    <= req_n;
      instr_valid <= valid_n;
      halted      <= halted_n;
      err_align   <= err_n;
      instr       <= instr_n;
      fetch_count <= count_n;
      squash      <= squash_n;
      pend_pc     <= pend_n;
    end
  end

endmodule
